pmod_pattern_sequencer: RTL and testbench
=========================================

Name: pmod_pattern_sequencer

Overview:
- Drives the board LEDs and PMOD output banks A-D with selectable animated patterns, stepping at a fixed human-visible rate from CLK_48.
- The board button, debounced, cycles through four modes: binary count, walking one, bounce and PWM breathe.
- Sits at top level between the raw button/clock pins and the PMOD/LED pads.

Parameters:
- STEP_DIV, 6000000, CLK_48 cycles per pattern step (8 steps/s at 48 MHz); minimum 2.
- DEBOUNCE_CYC, 480000, cycles BTN must be stable before the debounced level changes (10 ms); minimum 2.

Ports:
- CLK_48  input  1  system clock, 48 MHz.
- RST_N  input  1  asynchronous active-low reset.
- BTN  input  1  raw button, active-high, asynchronous to CLK_48.
- LED  output  1  heartbeat LED, active-low (0 = lit).
- LEDA  output  1  debounced button level.
- PMOD_OUT  output  32  bytes [7:0]=A, [15:8]=B, [23:16]=C, [31:24]=D; bit 7 of each byte = pin 1, bit 0 = pin 10.
- MODE  output  2  current mode: 0 COUNT, 1 WALK, 2 BOUNCE, 3 BREATHE.

Behaviour:
- Interface (decided): one clock, CLK_48; reset RST_N is asynchronous, active-low. All flops clear on RST_N=0 regardless of clock.
- Reset values: MODE=0, PMOD_OUT=0, LED=1 (off), LEDA=0, prescaler=0, pattern=0x00, duty=0, heartbeat=0, synchronizer and debounce state=0.
- BTN path: 2-flop synchronizer. The debounce counter clears whenever the synced level equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYC-1 the debounced level takes the synced level and the counter clears. A debounced 0->1 edge produces a one-cycle press pulse. Holding the button gives one press; glitches shorter than DEBOUNCE_CYC are ignored. LEDA = debounced level, registered.
- Prescaler: counts 0..STEP_DIV-1 and wraps. tick=1 in the cycle it equals STEP_DIV-1.
- Mode FSM: COUNT->WALK->BOUNCE->BREATHE->COUNT on each press. On a press, the prescaler clears, the pattern loads the new mode's initial value, direction is set to left, and duty=0.
- Press and tick in the same cycle: the press wins and the tick is discarded.
- Per tick, by mode:
  - COUNT: init 0x00; pattern+1 mod 256 (0xFF->0x00).
  - WALK: init 0x01; rotate left (0x80->0x01).
  - BOUNCE: init 0x01, dir=left; shift in dir; at 0x80 dir becomes right, at 0x01 dir becomes left. Sequence: 01,02,...,80,40,...,01,02.
  - BREATHE: duty triangle in steps of 16: 0,16,...,240, then 224,...,0, then 16, ...
- PWM: an 8-bit counter free-runs every cycle from reset. pwm_on = (pwm_cnt < duty); duty=0 gives always off.
- Outputs: each PMOD byte = pattern, or {8{pwm_on}} in BREATHE. PMOD_OUT is registered, so it updates one cycle after the pattern/duty update.
- Heartbeat: toggles every 4 ticks in all modes; LED = ~heartbeat, registered.
- MODE is the registered FSM state and changes the cycle after the press pulse.
- Reset mid-debounce or mid-step returns everything to its reset values; there is no partial-state carry-over.

Optional Feature:
- Macro PMOD_E_EN.
- Defined: PMOD_OUT widens to 40 bits; byte [39:32] = port E, driven with the bit-reversed pattern (mirror image), or {8{pwm_on}} in BREATHE, with the same timing and reset value 0.
- Undefined: PMOD_OUT is 32 bits and no port-E logic exists.

Test Plan:
- Bench parameters: STEP_DIV=4, DEBOUNCE_CYC=8.
- Reset: hold RST_N=0 and toggle BTN -> PMOD_OUT=0, LED=1, LEDA=0, MODE=0. Release, wait 3 ticks -> each byte = 0x03.
- Debounce: BTN pulses of 5 cycles, repeated -> MODE stays 0, LEDA stays 0. Hold BTN 20 cycles -> LEDA=1 and MODE=1 exactly once, PMOD bytes restart at 0x01.
- WALK wrap: from 0x80, one tick -> 0x01. In BOUNCE, 8 ticks from init -> 0x80 then 0x40, and 7 further ticks -> 0x01 then 0x02.
- BREATHE: 15 ticks -> duty=240, PMOD bytes high for 240 of every 256 cycles. Next tick -> duty=224. At duty=0, outputs stay 0.
- Collision: press pulse in the same cycle as tick in COUNT -> MODE=1, pattern=0x01, no extra step. Four presses total -> MODE wraps to 0, pattern=0x00.
- With PMOD_E_EN: WALK pattern 0x01 -> byte E=0x80; COUNT 0x03 -> byte E=0xC0.

Source files
------------

// File: rtl/pmod_pattern_sequencer_if.sv
// Pin bundle between pmod_pattern_sequencer and the board pads.
// Optional build macro: PMOD_E_EN widens PMOD_OUT from 32 to 40 bits (port E).
// master = sequencer side (drives LEDs/PMOD/MODE); slave = pad/board side (drives BTN).
interface pmod_pattern_sequencer_if;
`ifdef PMOD_E_EN
  localparam int PMOD_W = 40;
`else
  localparam int PMOD_W = 32;
`endif

  logic              BTN;
  logic              LED;
  logic              LEDA;
  logic [PMOD_W-1:0] PMOD_OUT;
  logic [1:0]        MODE;

  modport master (
    input  BTN,
    output LED,
    output LEDA,
    output PMOD_OUT,
    output MODE
  );

  modport slave (
    output BTN,
    input  LED,
    input  LEDA,
    input  PMOD_OUT,
    input  MODE
  );
endinterface

// File: rtl/pmod_pattern_sequencer.sv
// Animated LED/PMOD pattern generator. A debounced button steps through four
// modes (COUNT, WALK, BOUNCE, BREATHE); patterns advance once per STEP_DIV
// cycles of CLK_48. MODE exposes the FSM state directly for observation.
// Optional build macro: PMOD_E_EN adds port E (byte [39:32]) carrying the
// bit-mirrored pattern.
// Control strobes: press and tick are single-cycle pulses with no
// backpressure; they are consumed in the cycle they are high, and when both
// are high together press takes priority and the tick is dropped.
module pmod_pattern_sequencer #(
  parameter int STEP_DIV     = 6000000,
  parameter int DEBOUNCE_CYC = 480000
) (
  input  logic                    CLK_48,
  input  logic                    RST_N,
  pmod_pattern_sequencer_if.master pins
);

`ifdef PMOD_E_EN
  localparam int PMOD_W = 40;
`else
  localparam int PMOD_W = 32;
`endif
  localparam int PRE_W = $clog2(STEP_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    M_COUNT   = 2'd0,
    M_WALK    = 2'd1,
    M_BOUNCE  = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  // button path
  logic            btn_s1, btn_s2;
  logic            db_level, db_prev, leda_q;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // step timing
  logic [PRE_W-1:0] presc;
  logic             tick, step;

  // mode FSM and pattern datapath
  mode_e       state_q, state_d;
  logic [7:0]  pattern_q, pat_next, init_pattern;
  logic [7:0]  duty_q, duty_next;
  logic        dir_q, dir_next;   // 0 = left / duty rising, 1 = right / duty falling
  logic        is_breathe;

  // PWM, heartbeat, outputs
  logic [7:0]        pwm_cnt;
  logic              pwm_on;
  logic [1:0]        hb_cnt;
  logic              hb_q, led_q;
  logic [7:0]        out_byte;
  logic [PMOD_W-1:0] pmod_q;

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= pins.BTN;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: level follows the synced input only after it has differed for DEBOUNCE_CYC cycles
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      leda_q   <= 1'b0;
    end else begin
      db_prev <= db_level;
      leda_q  <= db_level;
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_level & ~db_prev;

  // Step prescaler; restarted by a press so a new mode begins a full step period
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
    end else if (press || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRE_LAST);
  assign step = tick & ~press;

  // FSM state register
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= M_COUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: advance one mode per press
  always_comb begin
    state_d = state_q;
    if (press) begin
      case (state_q)
        M_COUNT:   state_d = M_WALK;
        M_WALK:    state_d = M_BOUNCE;
        M_BOUNCE:  state_d = M_BREATHE;
        M_BREATHE: state_d = M_COUNT;
        default:   state_d = M_COUNT;
      endcase
    end
  end

  // FSM outputs: per-mode step of pattern/duty/direction and the entry pattern of the next mode
  always_comb begin
    pat_next   = pattern_q;
    duty_next  = duty_q;
    dir_next   = dir_q;
    is_breathe = 1'b0;
    case (state_q)
      M_COUNT: pat_next = pattern_q + 8'd1;
      M_WALK:  pat_next = {pattern_q[6:0], pattern_q[7]};
      M_BOUNCE: begin
        if (!dir_q) begin
          pat_next = {pattern_q[6:0], 1'b0};
          if (pat_next == 8'h80) dir_next = 1'b1;
        end else begin
          pat_next = {1'b0, pattern_q[7:1]};
          if (pat_next == 8'h01) dir_next = 1'b0;
        end
      end
      M_BREATHE: begin
        is_breathe = 1'b1;
        if (!dir_q) begin
          duty_next = duty_q + 8'd16;
          if (duty_next == 8'd240) dir_next = 1'b1;
        end else begin
          duty_next = duty_q - 8'd16;
          if (duty_next == 8'd0) dir_next = 1'b0;
        end
      end
      default: ;
    endcase
    init_pattern = ((state_d == M_WALK) || (state_d == M_BOUNCE)) ? 8'h01 : 8'h00;
  end

  // Pattern datapath: press reloads the entry state, otherwise advance on tick
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pattern_q <= 8'h00;
      duty_q    <= 8'h00;
      dir_q     <= 1'b0;
    end else if (press) begin
      pattern_q <= init_pattern;
      duty_q    <= 8'h00;
      dir_q     <= 1'b0;
    end else if (tick) begin
      pattern_q <= pat_next;
      duty_q    <= duty_next;
      dir_q     <= dir_next;
    end
  end

  // Free-running PWM counter
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign pwm_on = (pwm_cnt < duty_q);

  // Heartbeat toggles every fourth accepted step; LED is active-low
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      hb_cnt <= 2'd0;
      hb_q   <= 1'b0;
      led_q  <= 1'b1;
    end else begin
      led_q <= ~hb_q;
      if (step) begin
        hb_cnt <= hb_cnt + 2'd1;
        if (hb_cnt == 2'd3) hb_q <= ~hb_q;
      end
    end
  end

  // Byte presented on every port: pattern, or the PWM level while breathing
  always_comb begin
    out_byte = is_breathe ? {8{pwm_on}} : pattern_q;
  end

`ifdef PMOD_E_EN
  logic [7:0] e_byte;

  // Port E carries the mirror image of the pattern
  always_comb begin
    e_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      e_byte[i] = pattern_q[7-i];
    end
    if (is_breathe) e_byte = {8{pwm_on}};
  end

  // Registered pad drive for ports A-E
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pmod_q <= '0;
    end else begin
      pmod_q <= {e_byte, {4{out_byte}}};
    end
  end
`else
  // Registered pad drive for ports A-D
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pmod_q <= '0;
    end else begin
      pmod_q <= {4{out_byte}};
    end
  end
`endif

  assign pins.LED      = led_q;
  assign pins.LEDA     = leda_q;
  assign pins.PMOD_OUT = pmod_q;
  assign pins.MODE     = state_q;

endmodule

// File: tb/tb_pmod_pattern_sequencer.sv
// Directed bench for pmod_pattern_sequencer with STEP_DIV=4, DEBOUNCE_CYC=8.
// Optional build macro: PMOD_E_EN (expects the 40-bit PMOD_OUT with mirrored port E).
module tb_pmod_pattern_sequencer;

`ifdef PMOD_E_EN
  localparam int PW = 40;
`else
  localparam int PW = 32;
`endif

  logic CLK_48;
  logic RST_N;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  pmod_pattern_sequencer_if pins();

  pmod_pattern_sequencer #(
    .STEP_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .CLK_48 (CLK_48),
    .RST_N  (RST_N),
    .pins   (pins)
  );

  // clock / reset block
  initial CLK_48 = 1'b0;
  always #5 CLK_48 = ~CLK_48;

  // posedges since reset release; the DUT PWM counter equals this mod 256
  always @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [PW-1:0] exp_pat(input logic [7:0] p);
`ifdef PMOD_E_EN
    return {rev8(p), {4{p}}};
`else
    return {4{p}};
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_48);
  endtask

  // Hold the button long enough to register; returns 13 cycles after the rise,
  // when the new mode and its entry pattern are on the outputs.
  task automatic press_hold();
    pins.BTN = 1'b1;
    wait_cyc(13);
  endtask

  // Finish a 20-cycle hold and let the release debounce settle. Ends 21 cycles
  // after the mode change: 5 steps taken, next step lands 3 cycles later.
  task automatic press_release();
    wait_cyc(7);
    pins.BTN = 1'b0;
    wait_cyc(12);
  endtask

  // Four consecutive samples of one breathe step against the PWM model.
  task automatic chk_breathe(input string tag, input int duty);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = ((((cyc - 1) & 255)) < duty) ? 8'hFF : 8'h00;
      check_eq(tag, 64'(pins.PMOD_OUT), 64'(exp_pat(b)));
      wait_cyc(1);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    RST_N    = 1'b0;
    pins.BTN = 1'b0;

    // reset held while the button chatters
    for (int i = 0; i < 6; i++) begin
      wait_cyc(1);
      pins.BTN = ~pins.BTN;
    end
    wait_cyc(2);
    check_eq("rst_pmod", 64'(pins.PMOD_OUT), 64'd0);
    check_eq("rst_led",  64'(pins.LED),  64'd1);
    check_eq("rst_leda", 64'(pins.LEDA), 64'd0);
    check_eq("rst_mode", 64'(pins.MODE), 64'd0);

    pins.BTN = 1'b0;
    RST_N    = 1'b1;
    wait_cyc(12);
    check_eq("count_2", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h02)));
    wait_cyc(1);
    check_eq("count_3", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h03)));
    wait_cyc(3);
    check_eq("hb_led_before", 64'(pins.LED), 64'd1);
    wait_cyc(1);
    check_eq("hb_led_after", 64'(pins.LED), 64'd0);
    check_eq("count_4", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h04)));

    // short glitches must be filtered
    for (int r = 0; r < 3; r++) begin
      pins.BTN = 1'b1;
      wait_cyc(5);
      pins.BTN = 1'b0;
      wait_cyc(5);
    end
    wait_cyc(12);
    check_eq("glitch_mode", 64'(pins.MODE), 64'd0);
    check_eq("glitch_leda", 64'(pins.LEDA), 64'd0);

    // press 1: COUNT -> WALK
    press_hold();
    check_eq("p1_mode", 64'(pins.MODE), 64'd1);
    check_eq("p1_leda", 64'(pins.LEDA), 64'd1);
    check_eq("p1_init", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));
    press_release();
    check_eq("p1_once", 64'(pins.MODE), 64'd1);
    check_eq("p1_leda_rel", 64'(pins.LEDA), 64'd0);
    check_eq("walk_5", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h20)));
    wait_cyc(8);
    check_eq("walk_80", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h80)));
    wait_cyc(4);
    check_eq("walk_wrap", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));

    // press 2: WALK -> BOUNCE
    press_hold();
    check_eq("p2_mode", 64'(pins.MODE), 64'd2);
    check_eq("p2_init", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));
    press_release();
    check_eq("bounce_5", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h20)));
    wait_cyc(8);
    check_eq("bounce_7", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h80)));
    wait_cyc(4);
    check_eq("bounce_8", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h40)));
    wait_cyc(20);
    check_eq("bounce_13", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h02)));
    wait_cyc(4);
    check_eq("bounce_14", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));
    wait_cyc(4);
    check_eq("bounce_15", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h02)));

    // press 3: BOUNCE -> BREATHE
    press_hold();
    check_eq("p3_mode", 64'(pins.MODE), 64'd3);
    check_eq("p3_init", 64'(pins.PMOD_OUT), 64'd0);
    press_release();
    chk_breathe("breathe_80", 80);
    wait_cyc(36);
    chk_breathe("breathe_240", 240);
    chk_breathe("breathe_224", 224);
    wait_cyc(52);
    chk_breathe("breathe_0", 0);
    chk_breathe("breathe_16", 16);

    // press 4: BREATHE -> COUNT (wrap)
    press_hold();
    check_eq("p4_mode", 64'(pins.MODE), 64'd0);
    check_eq("p4_init", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h00)));
    press_release();
    check_eq("p4_count_5", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h05)));

    // press 5 lands on a step boundary in COUNT: press wins, tick dropped
    press_hold();
    check_eq("coll_mode", 64'(pins.MODE), 64'd1);
    check_eq("coll_init", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));
    wait_cyc(2);
    check_eq("coll_hold", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h01)));
    wait_cyc(1);
    check_eq("coll_step", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h02)));
    wait_cyc(4);
    pins.BTN = 1'b0;
    wait_cyc(12);

    // reset mid-hold, mid-step: everything returns to reset values at once
    pins.BTN = 1'b1;
    wait_cyc(13);
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_pmod", 64'(pins.PMOD_OUT), 64'd0);
    check_eq("mid_rst_mode", 64'(pins.MODE), 64'd0);
    check_eq("mid_rst_leda", 64'(pins.LEDA), 64'd0);
    check_eq("mid_rst_led",  64'(pins.LED),  64'd1);
    pins.BTN = 1'b0;
    wait_cyc(3);
    RST_N = 1'b1;
    wait_cyc(13);
    check_eq("post_rst_3", 64'(pins.PMOD_OUT), 64'(exp_pat(8'h03)));
    check_eq("post_rst_mode", 64'(pins.MODE), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
